// File: rtl/breathing_light_array.sv
// Multi-channel breathing-LED controller: a shared triangle ramp feeds per-channel
// PWM outputs with off/on/breathe/blink modes, optional squaring and odd-channel stagger.
module breathing_light_array #(
  parameter int          CHANNELS = 4,
  parameter int          PWM_BITS = 8,
  parameter int unsigned STEP_0   = 58824,
  parameter int unsigned STEP_1   = 98039,
  parameter int unsigned STEP_2   = 137255,
  parameter int unsigned STEP_3   = 196078
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            speed,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic                  stagger,
  input  logic                  gamma_en,
  input  logic                  hold,
  output logic [CHANNELS-1:0]   light,
  output logic [PWM_BITS-1:0]   level,
  output logic                  cycle_start
);

  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_BLINK   = 2'b11
  } mode_t;

  logic [31:0]           step_cnt;
  logic [31:0]           step_last;
  logic                  tick;
  logic [1:0]            speed_q;
  logic                  dir_down;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [PWM_BITS-1:0]   lvl    [CHANNELS];
  logic [2*PWM_BITS-1:0] sq     [CHANNELS];
  logic [PWM_BITS-1:0]   duty   [CHANNELS];
  logic [PWM_BITS-1:0]   duty_q [CHANNELS];
  mode_t                 mode_q [CHANNELS];
  logic [CHANNELS-1:0]   blink_q;

  // Step length follows the registered speed so a lever change restarts cleanly.
  always_comb begin
    step_last = STEP_0 - 32'd1;
    case (speed_q)
      2'd0:    step_last = STEP_0 - 32'd1;
      2'd1:    step_last = STEP_1 - 32'd1;
      2'd2:    step_last = STEP_2 - 32'd1;
      default: step_last = STEP_3 - 32'd1;
    endcase
  end

  assign tick = (step_cnt == step_last);

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      lvl[i]  = (stagger && ((i % 2) == 1)) ? (MAX - level) : level;
      sq[i]   = {{PWM_BITS{1'b0}}, lvl[i]} * {{PWM_BITS{1'b0}}, lvl[i]};
      duty[i] = gamma_en ? sq[i][2*PWM_BITS-1:PWM_BITS] : lvl[i];
    end
  end

  // Ramp: speed change outranks hold, which outranks the step tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt    <= '0;
      level       <= '0;
      dir_down    <= 1'b0;
      cycle_start <= 1'b0;
      speed_q     <= speed;
    end else if (speed != speed_q) begin
      step_cnt    <= '0;
      level       <= '0;
      dir_down    <= 1'b0;
      cycle_start <= 1'b0;
      speed_q     <= speed;
    end else if (hold) begin
      cycle_start <= 1'b0;
    end else if (tick) begin
      step_cnt <= '0;
      if (dir_down) begin
        level <= level - ONE;
        if (level == ONE) begin
          dir_down    <= 1'b0;
          cycle_start <= 1'b1;
        end else begin
          cycle_start <= 1'b0;
        end
      end else begin
        level       <= level + ONE;
        cycle_start <= 1'b0;
        if (level == MAX - ONE) dir_down <= 1'b1;
      end
    end else begin
      step_cnt    <= step_cnt + 32'd1;
      cycle_start <= 1'b0;
    end
  end

  // Duty, mode and blink state are captured only on the last frame clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      light   <= '0;
      blink_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_q[i] <= '0;
        mode_q[i] <= MODE_OFF;
      end
    end else begin
      pwm_cnt <= pwm_cnt + ONE;
      for (int i = 0; i < CHANNELS; i++) begin
        case (mode_q[i])
          MODE_OFF:     light[i] <= 1'b0;
          MODE_ON:      light[i] <= 1'b1;
          MODE_BREATHE: light[i] <= (pwm_cnt < duty_q[i]);
          default:      light[i] <= blink_q[i];
        endcase
        if (pwm_cnt == MAX) begin
          duty_q[i]  <= duty[i];
          mode_q[i]  <= mode_t'(mode[2*i +: 2]);
          blink_q[i] <= lvl[i][PWM_BITS-1];
        end
      end
    end
  end

endmodule

// File: doc/breathing_light_array.md
# breathing_light_array

Multi-channel breathing-LED controller: one shared triangle brightness ramp drives `CHANNELS` independent PWM outputs. Each channel has its own mode (off / on / breathe / blink). Optional features:
- Gamma-style squaring of brightness.
- Anti-phase stagger of odd channels.
- Ramp freeze (`hold`).

It replaces single-LED breathing lights in the board top-level, taking the 2-bit speed lever directly.

## Interface
- `CHANNELS`, 4, number of LED outputs (1..16).
- `PWM_BITS`, 8, brightness/PWM resolution N; PWM frame = 2^N clocks; MAX = 2^N-1.
- `STEP_0`, 58824, clocks per brightness step at speed 0. Full breathe = 2·MAX·STEP clocks, so 0.6 s at 50 MHz, N=8.
- `STEP_1`, 98039, clocks per step at speed 1 (1.0 s).
- `STEP_2`, 137255, clocks per step at speed 2 (1.4 s).
- `STEP_3`, 196078, clocks per step at speed 3 (2.0 s).

Ports:
- `clk` in 1, single clock; all logic on rising edge.
- `rst` in 1, synchronous, active-high reset.
- `speed` in 2, selects STEP_0..STEP_3.
- `mode` in 2·CHANNELS, channel i at [2i+1:2i]: 00 off, 01 on, 10 breathe, 11 blink.
- `stagger` in 1, 1 = odd channels use MAX-level.
- `gamma_en` in 1, 1 = duty = (lvl·lvl)>>N.
- `hold` in 1, 1 = freeze ramp (PWM keeps running).
- `light` out CHANNELS, registered PWM outputs.
- `level` out N, current shared ramp level.
- `cycle_start` out 1, one-clock pulse when ramp returns to 0.

## Operation
Reset (while `rst`=1 at an edge):
- `light`=0, `level`=0, `cycle_start`=0.
- Direction = up, `step_cnt`=0, `pwm_cnt`=0, `duty_q`=0, `mode_q`=off.
- `speed_q` ← `speed`, so there is no spurious restart after reset.

Step timer:
- `step_cnt` counts 0..STEP_sel-1, then wraps.
- The wrap cycle is the step tick. STEP values ≥1; 32-bit counter.

Ramp on step tick:
- Up: `level`+1; if the new value is MAX, direction becomes down.
- Down: `level`-1; if the new value is 0, direction becomes up and `cycle_start`=1 in that same registered cycle.
- Sequence 0,1..MAX,MAX-1..0,1…; period 2·MAX steps; MAX and 0 each held one step.

Priority per cycle: speed change > hold > step tick.
- Speed change: `speed`≠`speed_q` gives `level`←0, direction up, `step_cnt`←0, `speed_q`←`speed`. No `cycle_start` pulse.
- Hold: `step_cnt`, `level` and direction frozen. `cycle_start`=0.

Per-channel level: lvl_i = (`stagger` & i odd) ? MAX-`level` : `level`.

Shaping: duty_i = `gamma_en` ? (lvl_i·lvl_i)>>N (2N-bit product, upper N bits) : lvl_i.

PWM:
- `pwm_cnt` is free-running 0..MAX, wrapping.
- In the cycle `pwm_cnt`==MAX, `duty_q[i]`←duty_i and `mode_q[i]`←mode_i. Duty and mode changes therefore never glitch mid-frame.
- `light[i]` register, by `mode_q[i]`:
  - off: 0.
  - on: 1.
  - breathe: (`pwm_cnt` < `duty_q[i]`).
  - blink: MSB of lvl_i latched at frame boundary (1 when lvl_i ≥ 2^(N-1)), constant for the frame.
- Breathe output is high exactly `duty_q` clocks per 2^N-clock frame. Duty 0 = never high; MAX = high MAX of 2^N.

## Timing
- First step tick: STEP_sel clocks after `rst` deasserts; `level`=1 on the following edge.
- `level`/`cycle_start` update on the tick edge; `cycle_start` width exactly 1 clock.
- `light` lags `pwm_cnt` by one clock (registered compare).
- Mode/duty/stagger/gamma changes reach `light` at the first frame starting after the change: latched at `pwm_cnt`==MAX, visible from the `pwm_cnt`==0 compare onward.
- Speed change: `level`=0 one clock after the `speed` edge; next tick STEP_new clocks later.
- `rst` mid-frame or mid-ramp: full return to reset state on that edge; `light` low the next cycle.
- `hold` asserted across a tick: tick suppressed; counting resumes from the frozen `step_cnt` on release.

## Test plan
Bench parameters: N=4, STEP_0=3, STEP_2=5.
- Reset: `rst` 3 clocks, all channels breathe, speed 0 → `light`=0, `level`=0, `cycle_start`=0; `level`=1 after 3 clocks from release.
- Ramp: speed 0, free run → `level` 0→15→0 in 90 clocks; `cycle_start` single pulse at clock 90, 180; no pulse at level 15.
- Duty: `hold`=1 at level 5, channel 0 breathe → 5 high of 16. With `gamma_en`=1 → 1 high (25>>4). With `stagger`=1, channel 1 → 10 high, no gamma.
- Speed change: at level 9 switch speed 0→2 → level 0 next clock, no `cycle_start`, level 1 after 5 clocks.
- Modes: channel 0 on → `light[0]`=1 constant. Off → 0. Blink → high only in frames with level ≥8. Mode write at `pwm_cnt`=6 → no change until next frame start.
- Mid-operation reset: `rst` one clock at level 12 descending → `level`=0, direction up, all `light`=0, restart as in first scenario.
